// File: rtl/ssd_pkg.sv
// ssd_pkg -- shared definitions for the seven-segment scan decoder.
//   * SSD_0 .. SSD_F : segment codes (bit 6 = G ... bit 0 = A, active-high)
//   * SSD_BLANK      : all segments off
//   * state_t        : per-dwell capture state machine encoding
package ssd_pkg;

  localparam logic [6:0] SSD_0     = 7'h3F;
  localparam logic [6:0] SSD_1     = 7'h06;
  localparam logic [6:0] SSD_2     = 7'h5B;
  localparam logic [6:0] SSD_3     = 7'h4F;
  localparam logic [6:0] SSD_4     = 7'h66;
  localparam logic [6:0] SSD_5     = 7'h6D;
  localparam logic [6:0] SSD_6     = 7'h7D;
  localparam logic [6:0] SSD_7     = 7'h07;
  localparam logic [6:0] SSD_8     = 7'h7F;
  localparam logic [6:0] SSD_9     = 7'h6F;
  localparam logic [6:0] SSD_A     = 7'h77;
  localparam logic [6:0] SSD_B     = 7'h7C;
  localparam logic [6:0] SSD_C     = 7'h39;
  localparam logic [6:0] SSD_D     = 7'h5E;
  localparam logic [6:0] SSD_E     = 7'h79;
  localparam logic [6:0] SSD_F     = 7'h71;
  localparam logic [6:0] SSD_BLANK = 7'h00;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HELD   = 2'd2
  } state_t;

endpackage

// File: rtl/ssd_pattern_decode.sv
// ssd_pattern_decode -- combinational segment-pattern lookup.
// Ports:
//   seg   [6:0] in  : segment pattern, G..A, active-high
//   valid       out : pattern is one of the 16 hex glyphs
//   blank       out : pattern is all segments off
//   value [3:0] out : decoded hex value (0 when not valid)
module ssd_pattern_decode
  import ssd_pkg::*;
(
  input  logic [6:0] seg,
  output logic       valid,
  output logic       blank,
  output logic [3:0] value
);

  always_comb begin
    valid = 1'b1;
    blank = 1'b0;
    value = 4'h0;
    case (seg)
      SSD_0:     value = 4'h0;
      SSD_1:     value = 4'h1;
      SSD_2:     value = 4'h2;
      SSD_3:     value = 4'h3;
      SSD_4:     value = 4'h4;
      SSD_5:     value = 4'h5;
      SSD_6:     value = 4'h6;
      SSD_7:     value = 4'h7;
      SSD_8:     value = 4'h8;
      SSD_9:     value = 4'h9;
      SSD_A:     value = 4'hA;
      SSD_B:     value = 4'hB;
      SSD_C:     value = 4'hC;
      SSD_D:     value = 4'hD;
      SSD_E:     value = 4'hE;
      SSD_F:     value = 4'hF;
      SSD_BLANK: begin
        valid = 1'b0;
        blank = 1'b1;
      end
      default:   valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/ssd_scan_decoder.sv
// ssd_scan_decoder -- recovers the digit values from a multiplexed
// seven-segment display bus by watching the segment and digit-enable lines.
//
// Parameters:
//   NUM_DIGITS    : multiplexed digit positions (1..8)
//   STABLE_CYCLES : consecutive unchanged cycles before a capture (2..255)
// Ports:
//   CLK                     in  : clock, all state on rising edge
//   RSTn                    in  : asynchronous active-low reset
//   SSDIn      [6:0]        in  : segment lines G..A
//   DigitSel   [N-1:0]      in  : digit enables, one-hot while a digit is driven
//   ErrClr                  in  : synchronous clear of ErrFlag
//   BCDOut     [4N-1:0]     out : decoded nibble per digit, digit i at [4i+3:4i]
//   DigitValid [N-1:0]      out : digit holds a decoded, non-blank value
//   FrameValid              out : one-cycle pulse once every digit was captured
//   ErrFlag                 out : sticky unrecognised-pattern flag
//
// Build option: define SSD_ACTIVE_LOW_EN for common-anode displays; SSDIn and
// DigitSel are then inverted ahead of the synchroniser.
module ssd_scan_decoder
  import ssd_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 8
) (
  input  logic                    CLK,
  input  logic                    RSTn,
  input  logic [6:0]              SSDIn,
  input  logic [NUM_DIGITS-1:0]   DigitSel,
  input  logic                    ErrClr,
  output logic [4*NUM_DIGITS-1:0] BCDOut,
  output logic [NUM_DIGITS-1:0]   DigitValid,
  output logic                    FrameValid,
  output logic                    ErrFlag
);

  localparam int         BUS_W    = 7 + NUM_DIGITS;
  localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);

  // ---------------------------------------------------------------- polarity
  logic [6:0]            ssd_pol;
  logic [NUM_DIGITS-1:0] sel_pol;

`ifdef SSD_ACTIVE_LOW_EN
  assign ssd_pol = ~SSDIn;
  assign sel_pol = ~DigitSel;
`else
  assign ssd_pol = SSDIn;
  assign sel_pol = DigitSel;
`endif

  // ------------------------------------------------------------ synchroniser
  // prev_reg holds the synchronised bus from one cycle earlier, so a change
  // is seen one edge after it leaves the second synchroniser flop.
  logic [BUS_W-1:0] sync1_reg, sync2_reg, prev_reg;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
      prev_reg  <= '0;
    end else begin
      sync1_reg <= {ssd_pol, sel_pol};
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;
    end
  end

  logic [6:0]            seg;
  logic [NUM_DIGITS-1:0] sel;
  logic                  sel_onehot;
  logic                  changed;

  assign seg        = sync2_reg[BUS_W-1:NUM_DIGITS];
  assign sel        = sync2_reg[NUM_DIGITS-1:0];
  assign sel_onehot = $onehot(sel);
  assign changed    = (sync2_reg != prev_reg);

  // ------------------------------------------------------------------ decode
  logic       dec_valid;
  logic       dec_blank;
  logic [3:0] dec_value;

  ssd_pattern_decode u_decode (
    .seg   (seg),
    .valid (dec_valid),
    .blank (dec_blank),
    .value (dec_value)
  );

  // --------------------------------------------------------------------- FSM
  state_t     state_reg, state_next;
  logic [7:0] cnt_reg, cnt_next;
  logic       capture;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // The capture fires on the edge at which the counter would step onto
  // STABLE_CYCLES-1.  With the cycle spent entering SETTLE this puts the
  // capture STABLE_CYCLES+2 edges after the pins last moved.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    capture    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (sel_onehot) begin
          state_next = SETTLE;
          cnt_next   = '0;
        end
      end
      SETTLE: begin
        if (!sel_onehot) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (changed) begin
          cnt_next = '0;
        end else if (cnt_reg + 8'd1 == CNT_LAST) begin
          capture    = 1'b1;
          state_next = HELD;
          cnt_next   = CNT_LAST;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      HELD: begin
        if (!sel_onehot) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (changed) begin
          state_next = SETTLE;
          cnt_next   = '0;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // ------------------------------------------------------- per-digit storage
  // sel is one-hot whenever capture is asserted, so it doubles as the
  // write-enable vector.
  logic [NUM_DIGITS-1:0] cap_bit;
  logic [3:0]            nibble_reg [NUM_DIGITS];
  logic                  dv_reg     [NUM_DIGITS];

  assign cap_bit = capture ? sel : '0;

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
          nibble_reg[gi] <= 4'h0;
          dv_reg[gi]     <= 1'b0;
        end else if (cap_bit[gi]) begin
          // Blank and unknown patterns keep the old nibble but drop valid.
          if (dec_valid) begin
            nibble_reg[gi] <= dec_value;
          end
          dv_reg[gi] <= dec_valid;
        end
      end

      assign BCDOut[4*gi +: 4] = nibble_reg[gi];
      assign DigitValid[gi]    = dv_reg[gi];
    end
  endgenerate

  // ------------------------------------------------------- frame and errors
  logic [NUM_DIGITS-1:0] mask_reg, mask_next;
  logic                  frame_reg;
  logic                  err_reg;
  logic                  new_err;

  // A full mask is reported and cleared on the following edge; a capture
  // landing on that edge still starts the next frame.
  assign mask_next = ((&mask_reg) ? '0 : mask_reg) | cap_bit;
  assign new_err   = capture & ~dec_valid & ~dec_blank;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      mask_reg  <= '0;
      frame_reg <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      mask_reg  <= mask_next;
      frame_reg <= &mask_reg;
      // A fresh error wins over a simultaneous clear.
      err_reg   <= (err_reg & ~ErrClr) | new_err;
    end
  end

  assign FrameValid = frame_reg;
  assign ErrFlag    = err_reg;

endmodule

// File: tb/tb_ssd_scan_decoder.sv
// tb_ssd_scan_decoder -- directed self-checking bench for ssd_scan_decoder
// (NUM_DIGITS=4, STABLE_CYCLES=8).  Stimulus is written in active-high terms
// and inverted on the way to the pins when SSD_ACTIVE_LOW_EN is defined.
module tb_ssd_scan_decoder;

  localparam int ND = 4;
  localparam int SC = 8;

`ifdef SSD_ACTIVE_LOW_EN
  localparam logic INV = 1'b1;
`else
  localparam logic INV = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RSTn;
  logic [6:0]    SSDIn;
  logic [ND-1:0] DigitSel;
  logic          ErrClr;
  logic [4*ND-1:0] BCDOut;
  logic [ND-1:0] DigitValid;
  logic          FrameValid;
  logic          ErrFlag;

  ssd_scan_decoder #(
    .NUM_DIGITS    (ND),
    .STABLE_CYCLES (SC)
  ) dut (
    .CLK        (CLK),
    .RSTn       (RSTn),
    .SSDIn      (SSDIn),
    .DigitSel   (DigitSel),
    .ErrClr     (ErrClr),
    .BCDOut     (BCDOut),
    .DigitValid (DigitValid),
    .FrameValid (FrameValid),
    .ErrFlag    (ErrFlag)
  );

  always #5 CLK = ~CLK;

  int vectors     = 0;
  int miscompares = 0;
  int fv_cnt      = 0;
  int cyc         = 0;
  int fv_cyc      = -1;
  int c_mark      = 0;

  logic [6:0] scan_pat [4];

  task automatic drive(input logic [6:0] seg, input logic [ND-1:0] sel);
    SSDIn    = seg ^ {7{INV}};
    DigitSel = sel ^ {ND{INV}};
  endtask

  // Advance n cycles, sampling on falling edges and recording FrameValid.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      cyc++;
      if (FrameValid === 1'b1) begin
        fv_cnt++;
        fv_cyc = cyc;
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    $display("check %-20s observed=%h expected=%h", tag, obs, exp);
    assert (obs === exp) else begin
      miscompares++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("%s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    scan_pat[0] = 7'h06;
    scan_pat[1] = 7'h4F;
    scan_pat[2] = 7'h66;
    scan_pat[3] = 7'h71;

    // Reset state
    RSTn   = 1'b0;
    ErrClr = 1'b0;
    drive(7'h00, 4'b0000);
    tick(3);
    check("rst_bcd",   32'(BCDOut),     32'h0);
    check("rst_dv",    32'(DigitValid), 32'h0);
    check("rst_fv",    32'(FrameValid), 32'h0);
    check("rst_err",   32'(ErrFlag),    32'h0);
    RSTn = 1'b1;
    tick(2);

    // Single digit: '2' on digit 0, capture exactly at edge 10
    drive(7'h5B, 4'b0001);
    tick(9);
    check("lat_edge9_bcd", 32'(BCDOut[3:0]), 32'h0);
    check("lat_edge9_dv",  32'(DigitValid[0]), 32'h0);
    tick(1);
    check("lat_edge10_bcd", 32'(BCDOut[3:0]), 32'h2);
    check("lat_edge10_dv",  32'(DigitValid[0]), 32'h1);
    tick(2);
    check("single_no_fv", 32'(fv_cnt), 32'd0);

    // Full scan 06,4F,66,71 -> F431 with one FrameValid pulse
    fv_cnt = 0;
    for (int d = 0; d < 4; d++) begin
      drive(scan_pat[d], 4'(1 << d));
      if (d == 3) c_mark = cyc;
      tick(12);
    end
    check("scan_fv_count", 32'(fv_cnt), 32'd1);
    check("scan_fv_timing", 32'(fv_cyc - c_mark), 32'd11);
    check("scan_bcd", 32'(BCDOut), 32'hF431);
    check("scan_dv",  32'(DigitValid), 32'hF);
    check("scan_err", 32'(ErrFlag), 32'h0);
    drive(7'h00, 4'b0000);
    tick(5);

    // Digit 1 pattern toggling every 5 cycles: never settles
    fv_cnt = 0;
    for (int r = 0; r < 4; r++) begin
      drive(7'h5B, 4'b0010);
      tick(5);
      drive(7'h66, 4'b0010);
      tick(5);
    end
    drive(7'h00, 4'b0000);
    tick(5);
    check("toggle_bcd", 32'(BCDOut), 32'hF431);
    check("toggle_dv",  32'(DigitValid), 32'hF);
    check("toggle_fv",  32'(fv_cnt), 32'd0);

    // Unknown pattern 12 on digit 2
    drive(7'h12, 4'b0100);
    tick(12);
    check("bad_err", 32'(ErrFlag), 32'h1);
    check("bad_dv",  32'(DigitValid), 32'hB);
    check("bad_bcd", 32'(BCDOut), 32'hF431);
    ErrClr = 1'b1;
    tick(1);
    ErrClr = 1'b0;
    check("errclr", 32'(ErrFlag), 32'h0);

    // ErrClr held on the very edge a new error is captured
    drive(7'h12, 4'b1000);
    tick(9);
    check("err_before_cap", 32'(ErrFlag), 32'h0);
    ErrClr = 1'b1;
    tick(1);
    ErrClr = 1'b0;
    check("err_clr_coincident", 32'(ErrFlag), 32'h1);
    check("err2_dv", 32'(DigitValid), 32'h3);
    tick(2);

    // Blank on digit 0: nibble kept, valid dropped, counts toward the frame
    drive(7'h00, 4'b0001);
    tick(12);
    check("blank_dv",  32'(DigitValid), 32'h2);
    check("blank_bcd", 32'(BCDOut), 32'hF431);
    fv_cnt = 0;
    drive(7'h7D, 4'b0010);
    c_mark = cyc;
    tick(12);
    check("frame2_fv_count",  32'(fv_cnt), 32'd1);
    check("frame2_fv_timing", 32'(fv_cyc - c_mark), 32'd11);
    check("frame2_bcd", 32'(BCDOut), 32'hF461);
    check("frame2_dv",  32'(DigitValid), 32'h2);

    // Two enables at once: no capture
    fv_cnt = 0;
    drive(7'h5B, 4'b0110);
    tick(20);
    check("multi_bcd", 32'(BCDOut), 32'hF461);
    check("multi_dv",  32'(DigitValid), 32'h2);
    check("multi_fv",  32'(fv_cnt), 32'd0);

    // Three digits captured, then reset in the middle of digit 3 settling
    for (int d = 0; d < 3; d++) begin
      drive(scan_pat[d], 4'(1 << d));
      tick(12);
    end
    check("pre_rst_bcd", 32'(BCDOut), 32'hF431);
    drive(7'h71, 4'b1000);
    tick(6);
    RSTn = 1'b0;
    #1;
    check("async_rst_bcd", 32'(BCDOut),     32'h0);
    check("async_rst_dv",  32'(DigitValid), 32'h0);
    check("async_rst_fv",  32'(FrameValid), 32'h0);
    check("async_rst_err", 32'(ErrFlag),    32'h0);
    tick(3);
    drive(7'h00, 4'b0000);
    RSTn = 1'b1;
    tick(2);
    fv_cnt = 0;
    drive(7'h71, 4'b1000);
    tick(12);
    check("post_rst_fv",  32'(fv_cnt), 32'd0);
    check("post_rst_bcd", 32'(BCDOut), 32'hF000);
    check("post_rst_dv",  32'(DigitValid), 32'h8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
